// File: rtl/controler_pkg.sv
// Shared types and limits for the matched-delay handshake controller.
package controler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    REQ   = 2'd2
  } state_t;

  localparam int unsigned MAX_DELAY = 255;

  // A DELAY of 0 still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned delay);
    return (delay < 1) ? 1 : $clog2(delay + 1);
  endfunction

endpackage

// File: rtl/controler_edge_det.sv
// Registered rising-edge detector; an input already high out of reset is
// not reported until it has been sampled low once.
module controler_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic edge_o
);

  logic r_prev;
  logic r_armed;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev <= d_i;
      if (!d_i) r_armed <= 1'b1;
    end
  end

  assign edge_o = d_i & ~r_prev & r_armed;

endmodule

// File: rtl/controler.sv
// Matched-delay handshake stage: capture a token, wait DELAY cycles, request
// downstream. Optional one-deep token buffer under CONTROLER_PENDING_EN.
//
// state | meaning
// IDLE  | empty, waiting for an upstream request edge
// COUNT | token held, delay counter running down
// REQ   | req_out_o high, waiting for downstream acknowledge edge
module controler
  import controler_pkg::*;
#(
  parameter int unsigned DELAY = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_in_i,
  input  logic ack_out_i,
  output logic req_out_o,
  output logic ack_in_o
);

  localparam int unsigned CW = cnt_width(DELAY);
  localparam logic [CW-1:0] LOAD = CW'(DELAY);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_ack_in;
  logic          w_ack_nxt;
  logic          w_req_edge;
  logic          w_ack_edge;
  logic          w_accept;

  controler_edge_det u_req_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (req_in_i),
    .edge_o (w_req_edge)
  );

  controler_edge_det u_ack_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (ack_out_i),
    .edge_o (w_ack_edge)
  );

`ifdef CONTROLER_PENDING_EN
  logic r_pend;
  logic w_pend_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_pend <= 1'b0;
    else         r_pend <= w_pend_nxt;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_ack_in <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ack_in <= w_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    w_accept    = 1'b0;
`ifdef CONTROLER_PENDING_EN
    w_pend_nxt  = r_pend;
`endif
    case (r_state)
      IDLE: begin
        if (w_req_edge) w_accept = 1'b1;
      end
      COUNT: begin
        if (r_cnt == '0) w_state_nxt = REQ;
        else             w_cnt_nxt   = r_cnt - CW'(1);
`ifdef CONTROLER_PENDING_EN
        if (w_req_edge) w_pend_nxt = 1'b1;
`endif
      end
      REQ: begin
`ifdef CONTROLER_PENDING_EN
        if (w_ack_edge) begin
          // One token leaves now; if both a stored and a fresh one exist, keep the other.
          if (w_req_edge || r_pend) w_accept = 1'b1;
          else                      w_state_nxt = IDLE;
          w_pend_nxt = r_pend & w_req_edge;
        end else if (w_req_edge) begin
          w_pend_nxt = 1'b1;
        end
`else
        if (w_ack_edge) begin
          if (w_req_edge) w_accept = 1'b1;
          else            w_state_nxt = IDLE;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_accept) begin
      w_state_nxt = COUNT;
      w_cnt_nxt   = LOAD;
      w_ack_nxt   = 1'b1;
    end
  end

  assign req_out_o = (r_state == REQ);
  assign ack_in_o  = r_ack_in;

endmodule

// File: tb/tb_controler.sv
// Directed bench for controler: single token, DELAY=0, back-to-back tokens,
// simultaneous ack/req, a two-stage chain and reset behaviour.
module tb_controler;

`ifdef CONTROLER_PENDING_EN
  localparam logic PEND = 1'b1;
`else
  localparam logic PEND = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic a_req = 1'b0, a_ack = 1'b0, a_rout, a_ain;
  logic z_req = 1'b0, z_ack = 1'b0, z_rout, z_ain;
  logic b_req = 1'b0, b_ack = 1'b0, b_rout, b_ain;
  logic c_req = 1'b0, c_ack = 1'b0;
  logic s1_rout, s1_ain, s2_rout, s2_ain;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  controler #(.DELAY(25)) u_a (.clk_i(clk_i), .rst_ni(rst_ni), .req_in_i(a_req),
    .ack_out_i(a_ack), .req_out_o(a_rout), .ack_in_o(a_ain));
  controler #(.DELAY(0)) u_z (.clk_i(clk_i), .rst_ni(rst_ni), .req_in_i(z_req),
    .ack_out_i(z_ack), .req_out_o(z_rout), .ack_in_o(z_ain));
  controler #(.DELAY(3)) u_b (.clk_i(clk_i), .rst_ni(rst_ni), .req_in_i(b_req),
    .ack_out_i(b_ack), .req_out_o(b_rout), .ack_in_o(b_ain));
  controler #(.DELAY(25)) u_s1 (.clk_i(clk_i), .rst_ni(rst_ni), .req_in_i(c_req),
    .ack_out_i(s2_ain), .req_out_o(s1_rout), .ack_in_o(s1_ain));
  controler #(.DELAY(15)) u_s2 (.clk_i(clk_i), .rst_ni(rst_ni), .req_in_i(s1_rout),
    .ack_out_i(c_ack), .req_out_o(s2_rout), .ack_in_o(s2_ain));

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  initial begin
    step(2);
    rst_ni = 1'b1;
    step(2);
    check("rst_a_req_out", a_rout, 1'b0);
    check("rst_a_ack_in", a_ain, 1'b0);
    check("rst_b_req_out", b_rout, 1'b0);
    check("rst_s2_req_out", s2_rout, 1'b0);

    // single token, DELAY=25, with an ignored ack edge during COUNT
    a_req = 1'b1; step(1);                       // edge k
    check("a_ack_pulse", a_ain, 1'b1);
    check("a_req_low_k", a_rout, 1'b0);
    a_req = 1'b0; step(1);                       // k+1
    check("a_ack_once", a_ain, 1'b0);
    step(4);
    a_ack = 1'b1; step(1); a_ack = 1'b0;         // k+6
    check("a_ack_in_count", a_rout, 1'b0);
    step(19);                                    // k+25
    check("a_req_k25", a_rout, 1'b0);
    step(1);                                     // k+26
    check("a_req_k26", a_rout, 1'b1);
    step(4);
    check("a_req_hold", a_rout, 1'b1);
    check("a_no_extra_ack", a_ain, 1'b0);
    a_ack = 1'b1; step(1); a_ack = 1'b0;
    check("a_req_cleared", a_rout, 1'b0);
    step(3);
    check("a_idle", a_rout, 1'b0);

    // DELAY=0, request held high afterwards
    z_req = 1'b1; step(1);
    check("z_ack_pulse", z_ain, 1'b1);
    check("z_req_k", z_rout, 1'b0);
    step(1);
    check("z_req_k1", z_rout, 1'b1);
    check("z_ack_once", z_ain, 1'b0);
    z_ack = 1'b1; step(1); z_ack = 1'b0;
    check("z_req_cleared", z_rout, 1'b0);
    step(3);
    check("z_level_no_token", z_rout, 1'b0);
    check("z_level_no_ack", z_ain, 1'b0);
    z_req = 1'b0;

    // back-to-back tokens, DELAY=3
    b_req = 1'b1; step(1);                       // k
    check("b2b_ack1", b_ain, 1'b1);
    b_req = 1'b0; step(1);                       // k+1
    b_req = 1'b1; step(1);                       // k+2, edge in COUNT
    check("b2b_no_ack_in_count", b_ain, 1'b0);
    b_req = 1'b0; step(1);                       // k+3
    check("b2b_req_k3", b_rout, 1'b0);
    step(1);                                     // k+4
    check("b2b_req_k4", b_rout, 1'b1);
    b_ack = 1'b1; step(1); b_ack = 1'b0;         // m
    check("b2b_req_drop", b_rout, 1'b0);
    check("b2b_ack2", b_ain, PEND);
    step(1);
    check("b2b_ack2_once", b_ain, 1'b0);
    step(2);                                     // m+3
    check("b2b_req2_m3", b_rout, 1'b0);
    step(1);                                     // m+4
    check("b2b_req2_m4", b_rout, PEND);
    b_ack = 1'b1; step(1); b_ack = 1'b0;
    check("b2b_final_idle", b_rout, 1'b0);
    step(2);

    // simultaneous ack and new request while in REQ
    b_req = 1'b1; step(1);
    check("sim_ack1", b_ain, 1'b1);
    b_req = 1'b0; step(4);
    check("sim_req_up", b_rout, 1'b1);
    b_req = 1'b1; b_ack = 1'b1; step(1);         // m
    check("sim_req_drop", b_rout, 1'b0);
    check("sim_ack2", b_ain, 1'b1);
    b_req = 1'b0; b_ack = 1'b0; step(3);         // m+3
    check("sim_req_m3", b_rout, 1'b0);
    check("sim_ack2_once", b_ain, 1'b0);
    step(1);                                     // m+4
    check("sim_req_m4", b_rout, 1'b1);
    b_ack = 1'b1; step(1); b_ack = 1'b0;
    check("sim_final_idle", b_rout, 1'b0);
    step(2);

    // two-stage chain, DELAY 25 then 15
    c_req = 1'b1; step(1);                       // k
    c_req = 1'b0; step(25);                      // k+25
    check("ch_s1_k25", s1_rout, 1'b0);
    step(1);                                     // k+26
    check("ch_s1_k26", s1_rout, 1'b1);
    check("ch_s2_ack_k26", s2_ain, 1'b0);
    step(1);                                     // k+27, stage 2 captures
    check("ch_s2_ack_k27", s2_ain, 1'b1);
    check("ch_s1_hold_k27", s1_rout, 1'b1);
    step(1);                                     // k+28
    check("ch_s1_drop_k28", s1_rout, 1'b0);
    check("ch_s2_ack_once", s2_ain, 1'b0);
    step(14);                                    // k+42
    check("ch_s2_k42", s2_rout, 1'b0);
    step(1);                                     // k+43
    check("ch_s2_k43", s2_rout, 1'b1);
    step(5);
    check("ch_s2_hold", s2_rout, 1'b1);
    check("ch_s1_stays_low", s1_rout, 1'b0);
    c_ack = 1'b1; step(1); c_ack = 1'b0;
    check("ch_s2_cleared", s2_rout, 1'b0);
    step(2);

    // reset in mid-COUNT, then a level already high across reset release
    b_req = 1'b1; step(1);
    b_req = 1'b0;
    check("rst_pre_ack", b_ain, 1'b1);
    #1 rst_ni = 1'b0;
    z_req = 1'b1;
    #1;
    check("rst_async_ack", b_ain, 1'b0);
    check("rst_async_req", b_rout, 1'b0);
    step(2);
    rst_ni = 1'b1;
    step(8);
    check("rst_token_lost", b_rout, 1'b0);
    check("rst_no_ack", b_ain, 1'b0);
    check("rst_level_not_edge", z_ain, 1'b0);
    z_req = 1'b0; step(1);
    z_req = 1'b1; step(1);
    check("rst_rearm_ack", z_ain, 1'b1);
    step(1);
    check("rst_rearm_req", z_rout, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/controler.md
CONTROLER -- requirements
Module: controler

Interface
REQ-001 Parameter DELAY, default 10, range 0..255: matched-delay length in clock cycles between token capture and downstream request.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assertion, active-low.
REQ-004 req_in_i  input  1  upstream request; a token is signalled by a rising edge, pulse or level.
REQ-005 ack_out_i  input  1  downstream acknowledge; a rising edge releases the current token.
REQ-006 req_out_o  output  1  downstream request level; high while the token waits for acknowledge.
REQ-007 ack_in_o  output  1  upstream acknowledge; one-cycle pulse when a token is captured.

Function
REQ-008 Inputs are sampled on clk_i and rising-edge detected internally; edge = current & ~previous sample, with the previous sample reset to 0.
REQ-009 States: IDLE (empty), COUNT (delay running), REQ (req_out_o high, awaiting ack).
REQ-010 IDLE with a req_in_i edge: at that clock edge, go to COUNT, load counter with DELAY, and drive ack_in_o high for exactly the following cycle.
REQ-011 COUNT: decrement the counter each cycle; while counter==0, the next clock edge goes to REQ and sets req_out_o=1.
REQ-012 Latency: req_in_i edge sampled at clock edge k gives req_out_o high from edge k+DELAY+1; DELAY=0 gives edge k+1.
REQ-013 REQ with an ack_out_i edge: clear req_out_o at that clock edge and return to IDLE, unless a new token is accepted in the same cycle.
REQ-014 REQ with simultaneous ack_out_i edge and req_in_i edge: accept the new token directly (COUNT, counter=DELAY, ack_in_o pulse), and drop req_out_o for at least DELAY+1 cycles.
REQ-015 ack_out_i edges in IDLE or COUNT are ignored and raise no error.
REQ-016 req_in_i edges in COUNT or REQ that are not covered by REQ-014 are handled per REQ-021/REQ-022.
REQ-017 ack_in_o never pulses more than once per accepted token; req_out_o has exactly one rising edge per token.
REQ-018 Counter width is $clog2(DELAY+1), minimum 1; the counter never wraps (it stops at 0).

Reset
REQ-019 When rst_ni is low: immediately (asynchronously) set state IDLE, counter 0, pending flag 0, edge-detect registers 0, req_out_o=0, ack_in_o=0; any in-flight token is discarded.
REQ-020 After rst_ni deasserts, a req_in_i input already high is not seen as an edge until it has been sampled low once.

Configuration
REQ-021 With macro CONTROLER_PENDING_EN defined: one req_in_i edge arriving in COUNT or REQ is stored in a pending flag; on leaving REQ it is accepted as in REQ-010 (ack_in_o pulse, counter=DELAY); a second edge while pending is already set is dropped.
REQ-022 Without CONTROLER_PENDING_EN: req_in_i edges in COUNT or REQ, except the REQ-014 case, are dropped, with no ack_in_o pulse; the ports are identical in both builds.

Structure
REQ-023 Package controler_pkg holds the state enum typedef (IDLE, COUNT, REQ) and the maximum-DELAY constant (255).
REQ-024 Sub-module controler_edge_det (1-bit registered rising-edge detector with async active-low reset) is instantiated twice, once for req_in_i and once for ack_out_i.

Verification
REQ-025 Single token, DELAY=25: req_in_i pulse at edge 2 -> ack_in_o high during cycle 3; req_out_o high from edge 28 until ack_out_i rises.
REQ-026 Chain of two instances, DELAY=25 then DELAY=15, with stage-2 ack_in_o wired to stage-1 ack_out_i: one req pulse -> stage-1 req_out_o falls 1-2 cycles after stage-2 captures; stage-2 req_out_o rises 16 cycles after capture and holds until the final ack pulse.
REQ-027 DELAY=0: req_in_i edge at edge k -> req_out_o high at edge k+1.
REQ-028 Back-to-back tokens, DELAY=3: second req_in_i edge during COUNT -> with PENDING_EN, second ack_in_o pulse right after the first ack_out_i and a second req_out_o 4 cycles later; without PENDING_EN, no second pulse.
REQ-029 Simultaneous ack_out_i and req_in_i edges in REQ -> req_out_o drops, ack_in_o pulses, req_out_o re-rises after DELAY+1 cycles.
REQ-030 rst_ni asserted low in mid-COUNT -> outputs 0 immediately; no req_out_o afterward without a new req_in_i edge.
